// File: rtl/risc16_pkg.sv
// Shared RISC-16 definitions: datapath widths, NOP encoding and fetch state type.
package risc16_pkg;

    localparam int unsigned IMEM_ADDR_W  = 16;
    localparam int unsigned INSTR_W      = 16;
    localparam int unsigned FETCH_CNT_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select for the fetch stage: halt > redirect > stall > sequential advance.
module fetch_next_pc
    import risc16_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_W
) (
    input  logic                  run_i,
    input  logic                  halt_i,
    input  logic                  redirect_valid_i,
    input  logic                  stall_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  advance_o
);

    always_comb begin
        next_pc_o = pc_i;
        advance_o = 1'b0;
        if (run_i && !halt_i) begin
            if (redirect_valid_i) begin
                next_pc_o = redirect_pc_i;
            end else if (!stall_i) begin
                // Natural wrap at 2^ADDR_WIDTH; word-addressed so no alignment concerns
                next_pc_o = pc_i + ADDR_WIDTH'(1);
                advance_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-16 fetch stage: owns the PC, drives the instruction memory port and fills IF/ID.
module instr_fetch_unit
    import risc16_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = IMEM_ADDR_W,
    parameter int unsigned           INSTR_WIDTH = INSTR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   halt,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic                   if_valid,
    output logic                   halted,
    output logic [FETCH_CNT_W-1:0] fetch_count
);

    localparam logic [INSTR_WIDTH-1:0] NOP_W   = INSTR_WIDTH'(NOP_INSTR);
    localparam logic [FETCH_CNT_W-1:0] CNT_MAX = '1;

    fetch_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  if_instr_q, if_instr_d;
    logic [ADDR_WIDTH-1:0]   if_pc_q, if_pc_d;
    logic                    if_valid_q, if_valid_d;
    logic [FETCH_CNT_W-1:0]  fetch_count_q, fetch_count_d;
    logic                    advance;

    fetch_next_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc (
        .run_i            (state_q == FS_RUN),
        .halt_i           (halt),
        .redirect_valid_i (redirect_valid),
        .stall_i          (stall),
        .pc_i             (pc_q),
        .redirect_pc_i    (redirect_pc),
        .next_pc_o        (pc_d),
        .advance_o        (advance)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_RUN;
            pc_q          <= RESET_PC;
            if_instr_q    <= NOP_W;
            if_pc_q       <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // State transition and IF/ID update; HALT freezes everything until reset
    always_comb begin
        state_d       = state_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            FS_RUN: begin
                if (halt) begin
                    state_d    = FS_HALT;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_W;
                end else if (redirect_valid) begin
                    // Squash the wrong-path word fetched this cycle
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_W;
                end else if (advance) begin
                    if_instr_d = instr_in;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (fetch_count_q != CNT_MAX) begin
                        fetch_count_d = fetch_count_q + FETCH_CNT_W'(1);
                    end
                end
            end
            FS_HALT: begin
                state_d = FS_HALT;
            end
            default: begin
                state_d = FS_RUN;
            end
        endcase
    end

    assign pc_out      = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == FS_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle reference model plus directed literal checks.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, kept as plain integers
    int m_pc, m_instr, m_ifpc, m_valid, m_halted, m_count;
    int saved_pc;

    instr_fetch_unit #(
        .ADDR_WIDTH  (16),
        .INSTR_WIDTH (16),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mem_word(input int addr);
        if (addr == 0) return 'h2481;
        return ((addr * 37) + 'h1357) % 65536;
    endfunction

    assign instr_in = 16'(mem_word(int'(pc_out)));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: priority halt > redirect > stall > advance; halted state ignores all but reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_halted = 0; m_count = 0;
        end else if (m_halted == 0) begin
            if (halt) begin
                m_halted = 1; m_valid = 0; m_instr = 0;
            end else if (redirect_valid) begin
                m_pc = int'(redirect_pc); m_valid = 0; m_instr = 0;
            end else if (!stall) begin
                m_instr = mem_word(m_pc);
                m_ifpc  = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 1) % 65536;
                if (m_count < 65535) m_count = m_count + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("pc_out",      int'(pc_out),      m_pc);
        check("if_instr",    int'(if_instr),    m_instr);
        check("if_valid",    int'(if_valid),    m_valid);
        check("halted",      int'(halted),      m_halted);
        check("fetch_count", int'(fetch_count), m_count);
        if (m_valid == 1) check("if_pc", int'(if_pc), m_ifpc);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc",    int'(pc_out),      0);
        check("rst_valid", int'(if_valid),    0);
        check("rst_instr", int'(if_instr),    0);
        check("rst_count", int'(fetch_count), 0);
        rst = 1'b0;

        // First fetch from address 0
        @(negedge clk); #1;
        check("t1_instr", int'(if_instr), 'h2481);
        check("t1_ifpc",  int'(if_pc),    0);
        check("t1_valid", int'(if_valid), 1);
        check("t1_pc",    int'(pc_out),   1);

        // Stall three cycles at pc=5
        repeat (4) @(negedge clk);
        #1;
        check("t2_pc_pre", int'(pc_out), 5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t2_pc_hold",    int'(pc_out),      5);
            check("t2_ifpc_hold",  int'(if_pc),       4);
            check("t2_instr_hold", int'(if_instr),    mem_word(4));
            check("t2_count_hold", int'(fetch_count), 5);
        end
        stall = 1'b0;
        @(negedge clk); #1;
        check("t2_resume_ifpc", int'(if_pc),       5);
        check("t2_resume_cnt",  int'(fetch_count), 6);

        // Redirect wins over stall, exactly one bubble
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk); #1;
        stall = 1'b0; redirect_valid = 1'b0;
        check("t3_pc",    int'(pc_out),   'h40);
        check("t3_valid", int'(if_valid), 0);
        check("t3_instr", int'(if_instr), 0);
        @(negedge clk); #1;
        check("t3_ifpc",   int'(if_pc),    'h40);
        check("t3_valid1", int'(if_valid), 1);
        check("t3_count",  int'(fetch_count), 7);

        // PC wrap-around
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        check("t4_ifpc_ffff", int'(if_pc), 'hFFFF);
        @(negedge clk); #1;
        check("t4_ifpc_0", int'(if_pc),  0);
        check("t4_pc_1",   int'(pc_out), 1);

        // Async reset without a clock edge
        #2 rst = 1'b1;
        #1;
        check("t6_pc",    int'(pc_out),      0);
        check("t6_valid", int'(if_valid),    0);
        check("t6_instr", int'(if_instr),    0);
        check("t6_ifpc",  int'(if_pc),       0);
        check("t6_count", int'(fetch_count), 0);
        check("t6_halt",  int'(halted),      0);
        rst = 1'b0;

        // Saturating fetch counter
        repeat (65540) @(negedge clk);
        #1;
        check("t7_count_sat", int'(fetch_count), 'hFFFF);

        // Halt together with redirect: halt wins, then everything frozen
        saved_pc = m_pc;
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h1234;
        @(negedge clk); #1;
        halt = 1'b0;
        check("t5_halted", int'(halted),   1);
        check("t5_pc",     int'(pc_out),   saved_pc);
        check("t5_valid",  int'(if_valid), 0);
        for (int i = 0; i < 4; i++) begin
            stall = i[0]; redirect_valid = ~i[0]; redirect_pc = 16'(16'h0100 + i);
            @(negedge clk); #1;
            check("t5_pc_frozen", int'(pc_out), saved_pc);
            check("t5_still_halted", int'(halted), 1);
        end
        stall = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("t5_rst_pc",     int'(pc_out), 0);
        check("t5_rst_halted", int'(halted), 0);
        @(negedge clk); #1;
        check("t5_refetch", int'(if_instr), 'h2481);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
